// File: rtl/frame_sample_counter.sv
// Per-frame sample counter for the FFT input path: counts valid beats against a length
// latched at start, flags first/last beats, pulses frame_done and tracks a frame index.
module frame_sample_counter #(
  parameter int unsigned CNT_W = 32,
  parameter int unsigned FRM_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             cont_mode,
  input  logic [CNT_W-1:0] thresh,
  input  logic             valid,
  output logic             busy,
  output logic [CNT_W-1:0] count,
  output logic             first,
  output logic             last,
  output logic             frame_done,
  output logic [FRM_W-1:0] frame_idx,
  output logic             cfg_err
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             mode_q, mode_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [FRM_W-1:0] frame_idx_q, frame_idx_d;
  logic             frame_done_q, frame_done_d;
  logic             cfg_err_q, cfg_err_d;

  logic             in_run;
  logic             beat;
  logic             at_last;
  logic             start_ok;
  logic             start_bad;
  logic             frame_end;

  assign in_run    = (state_q == StRun);
  assign beat      = in_run & valid;
  // len_q is never zero in RUN, so len_q-1 cannot wrap while it matters.
  assign at_last   = (count_q == (len_q - CNT_W'(1)));
  assign start_ok  = (state_q == StIdle) & start & ~abort & (thresh != '0);
  assign start_bad = (state_q == StIdle) & start & ~abort & (thresh == '0);
  // Abort wins over a coincident last beat: no completion is recorded.
  assign frame_end = beat & at_last & ~abort;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start_ok) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (abort) begin
          state_d = StIdle;
        end else if (frame_end && !mode_q) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    busy       = in_run;
    count      = count_q;
    first      = beat & (count_q == '0);
    last       = beat & at_last;
    frame_done = frame_done_q;
    frame_idx  = frame_idx_q;
    cfg_err    = cfg_err_q;
  end

  // Datapath next-state
  always_comb begin
    len_d        = len_q;
    mode_d       = mode_q;
    count_d      = count_q;
    frame_idx_d  = frame_idx_q;
    frame_done_d = frame_end;
    cfg_err_d    = start_bad;

    if (abort) begin
      count_d = '0;
    end else if (start_ok) begin
      len_d       = thresh;
      mode_d      = cont_mode;
      count_d     = '0;
      frame_idx_d = '0;
    end else if (beat) begin
      if (at_last) begin
        count_d     = '0;
        frame_idx_d = frame_idx_q + FRM_W'(1);
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q        <= '0;
      mode_q       <= 1'b0;
      count_q      <= '0;
      frame_idx_q  <= '0;
      frame_done_q <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      len_q        <= len_d;
      mode_q       <= mode_d;
      count_q      <= count_d;
      frame_idx_q  <= frame_idx_d;
      frame_done_q <= frame_done_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

endmodule
